triangular_rom: RTL and testbench
=================================

# triangular_rom

Synchronous 16-bit-in, 16-bit-out lookup block that returns one sample of a symmetric unsigned triangle wave for a given phase address. It sits behind the DDS phase accumulator of the triangular-wave generator, which supplies the top 16 bits of the synthesised phase as `address`. The ROM contents are computed combinationally from the address rather than from an init file. This makes the block synthesisable without memory initialisation files.

## Interface
Parameters: none. Widths are fixed at 16-bit address and 16-bit data.

- `clock` — input, 1 bit. Single clock; all state updates on the rising edge.
- `reset` — input, 1 bit. Asynchronous, active-low reset.
- `address` — input, 16 bits. Phase index, unsigned, 0..65535; one full triangle period.
- `q` — output, 16 bits. Registered triangle sample, unsigned offset-binary, 0..65534.

## Operation
Transfer function f(a), with a = `address` as an unsigned 16-bit value:
- a[15] = 0 (rising half, a = 0..32767): f = {a[14:0], 1'b0} = 2·a.
- a[15] = 1 (falling half, a = 32768..65535): f = {~a[14:0], 1'b0} = 131070 − 2·a.

Properties of f:
- f(0) = 0.
- Peak is 65534, reached at both a = 32767 and a = 32768 (flat two-sample top).
- f(65535) = 0.
- Wrap-around 65535 → 0 is continuous: 0 → 0, a flat two-sample bottom.
- The LSB of q is always 0.
- No overflow is possible; all arithmetic is exact in 16 bits.

Behaviour:
- f is pure combinational logic on the registered address. There is no memory array and no write port.
- The block is stateless apart from the pipeline registers: an input address register and an output register `q`.
- The address stage and output stage are merged, so the effective latency is one rising edge (see Timing).
- X/undefined address bits must not be propagated intentionally; behaviour is defined only for a known address.

## Timing
- Latency is 1 clock: at rising edge n, `q` ← f(`address` sampled at edge n). `q` is stable for the whole following cycle.
- Upstream drives `address` on the falling edge of `clock`, so `address` is stable half a cycle before each rising edge. The block requires only standard setup/hold at the rising edge.
- Throughput is one new address per clock. Back-to-back different addresses each produce their own result exactly one edge later; there is no stalling and no handshake.
- Reset while low: `q` = 16'h0000 immediately and asynchronously, independent of `clock`. `q` holds 0 while `reset` is low.
- Reset deassertion: the first rising edge after `reset` goes high loads f(`address`). No extra warm-up cycles.
- Reset asserted mid-stream: `q` clears at once. Any in-flight sample is discarded, not delayed.
- Reset value of every register is 0; 0 is also a legal sample (f(0) = 0).

## Test plan
1. Reset: hold `reset` = 0 with `address` = 16384 and clock running → `q` = 0 throughout. Release; after 1 rising edge → `q` = 32768.
2. Rising-half points: apply `address` = 0, 1, 16384, 32767 on successive cycles → `q` = 0, 2, 32768, 65534, each appearing one edge after its address.
3. Falling-half points: apply `address` = 32768, 49152, 65534, 65535 → `q` = 65534, 32766, 2, 0.
4. Full sweep: step `address` +1 per clock from 0 to 65535, then wrap to 0. Compare every `q` against the reference model f with a 1-cycle delay. Check the LSB is always 0, the maximum is 65534, and the sequence 65535 → 0 gives `q` 0 → 0.
5. DDS-style stepping: step `address` by 4096 per clock starting from 0 → `q` = 0, 8192, 16384, …, 57344, 65534 (at 32768), 57342, …, 8190, then 0 again on wrap.
6. Async reset mid-stream: during scenario 4 at `address` = 20000, pulse `reset` low between clock edges → `q` goes to 0 without a clock edge. After release, the next edge yields f(current address).

Source files
------------

// File: rtl/triangular_rom_if.sv
// Phase-address / sample bus between the DDS phase accumulator and the triangle ROM.
// The accumulator side drives the address; the ROM side returns the registered sample.
interface triangular_rom_if;
   logic [15:0] address;
   logic [15:0] q;

   modport master (output address, input  q);
   modport slave  (input  address, output q);
endinterface

// File: rtl/triangular_rom.sv
// Symmetric unsigned triangle lookup: one registered sample per clock, computed from the phase address.
// The input and output stages are merged into a single register, so latency is exactly one rising edge.
module triangular_rom (
   input  logic             clock,
   input  logic             reset,
   triangular_rom_if.slave  bus
);

   // Falling half mirrors the rising half: inverting the low 15 bits gives a two-sample flat top and bottom.
   function automatic logic [15:0] tri_fold(input logic [15:0] a);
      logic [14:0] mag;
      mag = a[15] ? ~a[14:0] : a[14:0];
      return {mag, 1'b0};
   endfunction

   logic [15:0] q_p0;

   // Stage 0: address sampled and folded in the same edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_p0 <= '0;
      end else begin
         q_p0 <= tri_fold(bus.address);
      end
   end

   assign bus.q = q_p0;

endmodule

// File: tb/tb_triangular_rom.sv
// Bench for triangular_rom: vector table, DDS stepping, full sweep and async-reset sequences.
module tb_triangular_rom;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] exp;
   } vec_t;

   logic clock;
   logic reset;
   triangular_rom_if bus ();

   triangular_rom dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [15:0] exp_q[$];
   string       phase  = "idle";
   bit          sweeping = 1'b0;
   logic        lsb_or = 1'b0;
   logic [15:0] max_q  = '0;

   // Reference written in arithmetic form, independent of the bit-fold used by the design.
   function automatic logic [15:0] ref_f(input int a);
      int v;
      v = (a < 32768) ? 2 * a : 131070 - 2 * a;
      return v[15:0];
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: q=%0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop_and_check();
      logic [15:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check(phase, bus.q, e);
         if (sweeping) begin
            lsb_or = lsb_or | bus.q[0];
            if (bus.q > max_q) max_q = bus.q;
         end
      end
   endtask

   // Inputs change on the falling edge, so outputs are also compared there.
   task automatic drive(input logic [15:0] a, input logic [15:0] e);
      @(negedge clock);
      pop_and_check();
      bus.address = a;
      exp_q.push_back(e);
   endtask

   task automatic flush();
      @(negedge clock);
      pop_and_check();
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{16'd0,     16'd0};
      vecs[1] = '{16'd1,     16'd2};
      vecs[2] = '{16'd16384, 16'd32768};
      vecs[3] = '{16'd32767, 16'd65534};
      vecs[4] = '{16'd32768, 16'd65534};
      vecs[5] = '{16'd49152, 16'd32766};
      vecs[6] = '{16'd65534, 16'd2};
      vecs[7] = '{16'd65535, 16'd0};

      // Reset held low with a nonzero address: output stays cleared
      reset       = 1'b1;
      bus.address = 16'd16384;
      #1 reset = 1'b0;
      #1 check("reset_async", bus.q, 16'd0);
      repeat (3) begin
         @(negedge clock);
         check("reset_hold", bus.q, 16'd0);
      end
      reset = 1'b1;
      @(negedge clock);
      check("reset_release", bus.q, 16'd32768);

      phase = "table";
      for (int i = 0; i < 8; i++) drive(vecs[i].addr, vecs[i].exp);
      flush();

      phase = "dds";
      for (int k = 0; k < 16; k++) drive(16'(k * 4096), ref_f(k * 4096));
      drive(16'd0, 16'd0);
      flush();

      phase    = "sweep";
      sweeping = 1'b1;
      for (int i = 0; i < 65536; i++) drive(16'(i), ref_f(i));
      drive(16'd0, 16'd0);
      flush();
      sweeping = 1'b0;
      check("sweep_lsb", {15'd0, lsb_or}, 16'd0);
      check("sweep_max", max_q, 16'd65534);

      // Reset pulsed between edges while a sample is held
      phase = "mid_reset";
      drive(16'd19999, ref_f(19999));
      drive(16'd20000, ref_f(20000));
      @(posedge clock);
      #2;
      check("pre_reset", bus.q, exp_q.pop_front());
      reset = 1'b0;
      #1 check("mid_reset_async", bus.q, 16'd0);
      #1 reset = 1'b1;
      @(negedge clock);
      check("mid_reset_hold", bus.q, 16'd0);
      @(negedge clock);
      check("after_release", bus.q, 16'd40000);
      drive(16'd20001, ref_f(20001));
      flush();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
